// File: rtl/scale_demux_pkg.sv
// Shared types and constants for the scale_demux 1-to-2 registered demultiplexer.
package scale_demux_pkg;

  typedef enum logic {
    DEST_A = 1'b0,
    DEST_B = 1'b1
  } dest_e;

  localparam int DEMUX_WIDTH_DEF = 8;
  localparam int CNT_W           = 8;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot for a demux destination: load, drain and handshake count.
module demux_slot
  import scale_demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             free,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] cnt
);

  logic drain;

  assign drain = valid & ready;
  // A full slot still accepts when it drains in the same cycle, giving back-to-back transfers.
  assign free  = ~valid | ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      cnt   <= '0;
    end else begin
      if (load) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (drain) begin
        valid <= 1'b0;
      end
      if (drain) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/scale_demux.sv
// Registered 1-to-2 demux with per-destination holding slots and handshake counters.
// Define SCALE_DEMUX_RR_EN for round-robin distribution instead of in_sel steering.
module scale_demux
  import scale_demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
);

  dest_e dest;
  logic  a_free;
  logic  b_free;
  logic  accept;

`ifdef SCALE_DEMUX_RR_EN
  dest_e rr_ptr;
  logic  unused_sel;

  assign unused_sel = in_sel;
  assign dest       = rr_ptr;

  // A stalled destination holds the pointer, so the source stalls rather than skipping ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= DEST_A;
    end else if (accept) begin
      rr_ptr <= (rr_ptr == DEST_A) ? DEST_B : DEST_A;
    end
  end
`else
  assign dest = dest_e'(in_sel);
`endif

  assign in_ready = (dest == DEST_A) ? a_free : b_free;
  assign accept   = in_valid & in_ready;

  demux_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (accept & (dest == DEST_A)),
    .load_data (in_data),
    .ready     (a_ready),
    .free      (a_free),
    .data      (a_data),
    .valid     (a_valid),
    .cnt       (a_cnt)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (accept & (dest == DEST_B)),
    .load_data (in_data),
    .ready     (b_ready),
    .free      (b_free),
    .data      (b_data),
    .valid     (b_valid),
    .cnt       (b_cnt)
  );

endmodule

// File: tb/tb_scale_demux.sv
// Self-checking bench for scale_demux; define SCALE_DEMUX_RR_EN to exercise round-robin mode.
module tb_scale_demux;

`ifdef SCALE_DEMUX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic [7:0] a_cnt, b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-destination occupancy, last delivered word, handshake totals.
  logic       m_valid[2];
  logic [7:0] m_data[2];
  int         m_cnt[2];
  int         m_rr;
  logic       exp_rdy;
  logic       act_rdy;

  scale_demux #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_cnt    (a_cnt),
    .b_cnt    (b_cnt)
  );

  always #5 clk = ~clk;

  // Drives one cycle of stimulus from just after a falling edge, advances the model at the
  // rising edge and returns on the next falling edge, where outputs are stable.
  task automatic step(input logic r, input logic v, input logic s, input logic [7:0] d,
                      input logic ar, input logic br);
    int  dst;
    logic rdy[2];
    logic acc, drain;
    rst = r; in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
    #1;
    rdy[0]  = ar;
    rdy[1]  = br;
    dst     = RR ? m_rr : int'(s);
    exp_rdy = !m_valid[dst] || rdy[dst];
    act_rdy = in_ready;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_valid[i] = 1'b0; m_data[i] = 8'h00; m_cnt[i] = 0;
      end
      m_rr = 0;
    end else begin
      acc = v && exp_rdy;
      for (int i = 0; i < 2; i++) begin
        drain = m_valid[i] && rdy[i];
        if (drain) m_cnt[i] = (m_cnt[i] + 1) % 256;
        if (acc && dst == i) begin
          m_data[i]  = d;
          m_valid[i] = 1'b1;
        end else if (drain) begin
          m_valid[i] = 1'b0;
        end
      end
      if (acc && RR) m_rr = 1 - m_rr;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 8'h00, 1, 1);
    step(0, 0, 0, 8'h00, 1, 1);
    n_checks++;
    if ({a_valid, b_valid, a_data, b_data, a_cnt, b_cnt} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {a_valid, b_valid, a_data, b_data, a_cnt, b_cnt});
    end
    n_checks++;
    if (act_rdy !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b required 1", act_rdy);
    end
  endtask

`ifndef SCALE_DEMUX_RR_EN
  task automatic test_single();
    step(0, 1, 0, 8'hFF, 1, 1);
    n_checks++;
    if ({a_valid, a_data, b_valid, a_cnt} !== {1'b1, 8'hFF, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL single_load: got av=%b ad=%h bv=%b ac=%0d required 1 ff 0 0", a_valid, a_data, b_valid, a_cnt);
    end
    step(0, 0, 0, 8'h00, 1, 1);
    n_checks++;
    if ({a_valid, a_data, b_valid, a_cnt} !== {1'b0, 8'hFF, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL single_drain: got av=%b ad=%h bv=%b ac=%0d required 0 ff 0 1", a_valid, a_data, b_valid, a_cnt);
    end
  endtask

  task automatic test_stall();
    logic [7:0] bc;
    bc = b_cnt;
    step(0, 1, 1, 8'h00, 1, 0);
    n_checks++;
    if ({b_valid, b_data} !== {1'b1, 8'h00} || act_rdy !== 1'b1) begin
      n_fail++; $display("FAIL stall_first: got bv=%b bd=%h rdy=%b required 1 00 1", b_valid, b_data, act_rdy);
    end
    step(0, 1, 1, 8'h55, 1, 0);
    n_checks++;
    if (act_rdy !== 1'b0 || b_data !== 8'h00) begin
      n_fail++; $display("FAIL stall_blocked: got rdy=%b bd=%h required 0 00", act_rdy, b_data);
    end
    step(0, 1, 0, 8'hAA, 1, 0);
    n_checks++;
    if (act_rdy !== 1'b1 || {a_valid, a_data, b_valid, b_data} !== {1'b1, 8'hAA, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL stall_switch: got rdy=%b av=%b ad=%h bv=%b bd=%h required 1 1 aa 1 00",
               act_rdy, a_valid, a_data, b_valid, b_data);
    end
    step(0, 0, 0, 8'h00, 1, 1);
    n_checks++;
    if (b_valid !== 1'b0 || b_cnt !== bc + 8'd1) begin
      n_fail++; $display("FAIL stall_release: got bv=%b bc=%0d required 0 %0d", b_valid, b_cnt, bc + 8'd1);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 8'h00, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 8'h10 + 8'(i), 1, 1);
      n_checks++;
      if (a_valid !== 1'b1 || a_data !== 8'h10 + 8'(i) || act_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_word%0d: got av=%b ad=%h rdy=%b required 1 %h 1", i, a_valid, a_data, act_rdy, 8'h10 + 8'(i));
      end
    end
    step(0, 0, 0, 8'h00, 1, 1);
    n_checks++;
    if (a_cnt !== 8'd4 || a_valid !== 1'b0) begin
      n_fail++; $display("FAIL stream_count: got ac=%0d av=%b required 4 0", a_cnt, a_valid);
    end
  endtask

  task automatic test_wrap_and_reset();
    step(1, 0, 0, 8'h00, 1, 1);
    for (int i = 0; i < 255; i++) step(0, 1, 0, 8'(i), 1, 1);
    step(0, 0, 0, 8'h00, 1, 1);
    n_checks++;
    if (a_cnt !== 8'd255) begin
      n_fail++; $display("FAIL wrap_255: got %0d required 255", a_cnt);
    end
    step(0, 1, 0, 8'h77, 1, 1);
    step(0, 0, 0, 8'h00, 1, 1);
    n_checks++;
    if (a_cnt !== 8'd0) begin
      n_fail++; $display("FAIL wrap_0: got %0d required 0", a_cnt);
    end
    step(0, 1, 0, 8'hC3, 0, 0);
    step(0, 1, 1, 8'h3C, 0, 0);
    n_checks++;
    if ({a_valid, a_data, b_valid, b_data} !== {1'b1, 8'hC3, 1'b1, 8'h3C}) begin
      n_fail++; $display("FAIL full_both: got %h required %h", {a_valid, a_data, b_valid, b_data}, {1'b1, 8'hC3, 1'b1, 8'h3C});
    end
    step(1, 1, 0, 8'h99, 1, 1);
    n_checks++;
    if ({a_valid, b_valid, a_data, b_data, a_cnt, b_cnt} !== 34'h0) begin
      n_fail++; $display("FAIL mid_reset: got %h required 0", {a_valid, b_valid, a_data, b_data, a_cnt, b_cnt});
    end
  endtask
`else
  task automatic test_round_robin();
    logic [7:0] exp_a[2];
    logic [7:0] exp_b[2];
    exp_a[0] = 8'd1; exp_a[1] = 8'd3;
    exp_b[0] = 8'd2; exp_b[1] = 8'd4;
    step(1, 0, 1, 8'h00, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 8'(i + 1), 1, 1);
      n_checks++;
      if (i % 2 == 0 ? (a_valid !== 1'b1 || a_data !== exp_a[i/2] || b_valid !== 1'b0)
                     : (b_valid !== 1'b1 || b_data !== exp_b[i/2] || a_valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL rr_word%0d: got av=%b ad=%h bv=%b bd=%h", i + 1, a_valid, a_data, b_valid, b_data);
      end
    end
    step(1, 0, 1, 8'h00, 1, 1);
    step(0, 1, 1, 8'd1, 1, 0);
    step(0, 1, 1, 8'd2, 1, 0);
    step(0, 1, 1, 8'd3, 1, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, 8'd4, 1, 0);
      n_checks++;
      if (act_rdy !== 1'b0 || b_data !== 8'd2) begin
        n_fail++; $display("FAIL rr_stall%0d: got rdy=%b bd=%h required 0 02", i, act_rdy, b_data);
      end
    end
    step(0, 1, 1, 8'd4, 1, 1);
    n_checks++;
    if (act_rdy !== 1'b1 || b_data !== 8'd4) begin
      n_fail++; $display("FAIL rr_resume: got rdy=%b bd=%h required 1 04", act_rdy, b_data);
    end
  endtask
`endif

  task automatic test_random();
    logic v, s, hold;
    logic [7:0] d;
    hold = 1'b0; s = 1'b0; d = 8'h00;
    step(1, 0, 0, 8'h00, 1, 1);
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        s = 1'($urandom);
        d = 8'($urandom);
      end
      step(0, v, s, d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
      hold = v && !exp_rdy;
      n_checks++;
      if (act_rdy !== exp_rdy) begin
        n_fail++; $display("FAIL rand_in_ready@%0d: got %b required %b", i, act_rdy, exp_rdy);
      end
      n_checks++;
      if ({a_valid, a_data, a_cnt} !== {m_valid[0], m_data[0], 8'(m_cnt[0])}) begin
        n_fail++;
        $display("FAIL rand_a@%0d: got v=%b d=%h c=%0d required v=%b d=%h c=%0d",
                 i, a_valid, a_data, a_cnt, m_valid[0], m_data[0], m_cnt[0]);
      end
      n_checks++;
      if ({b_valid, b_data, b_cnt} !== {m_valid[1], m_data[1], 8'(m_cnt[1])}) begin
        n_fail++;
        $display("FAIL rand_b@%0d: got v=%b d=%h c=%0d required v=%b d=%h c=%0d",
                 i, b_valid, b_data, b_cnt, m_valid[1], m_data[1], m_cnt[1]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = 8'h00; a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; m_data[i] = 8'h00; m_cnt[i] = 0;
    end
    m_rr = 0;
    @(negedge clk);
    test_reset();
`ifndef SCALE_DEMUX_RR_EN
    test_single();
    test_stall();
    test_back_to_back();
    test_wrap_and_reset();
`else
    test_round_robin();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scale_demux.md
# scale_demux

Registered 1-to-2 demultiplexer with per-output valid/ready handshake. It performs the inverse of `scale_mux`: one WIDTH-bit source stream is steered to destination A or B. Each destination has a one-entry holding slot, so a stalled destination never corrupts traffic to the other. It sits on the CPU's shared data path, where a single producer (memory/ALU result) feeds two consumers.

## Interface
- `WIDTH`, default 8: data width in bits, minimum 1.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input WIDTH: source data.
- `in_sel` input 1: destination select; 0 = A, 1 = B. Ignored when `SCALE_DEMUX_RR_EN` is defined.
- `in_valid` input 1: source offers `in_data`.
- `in_ready` output 1: demux accepts this cycle.
- `a_data` output WIDTH: destination A data.
- `a_valid` output 1: slot A holds data.
- `a_ready` input 1: destination A consumes.
- `b_data`, `b_valid`, `b_ready`: same as A, for destination B.
- `a_cnt` output 8: count of completed A handshakes.
- `b_cnt` output 8: count of completed B handshakes.

## Operation
- Destination select:
  - Without the macro, dest = `in_sel`.
  - With the macro, dest = internal pointer `rr_ptr`.
- `in_ready` = (slot[dest] empty) OR (slot[dest] valid AND its ready high). This is the only combinational path from an input to an output.
- Input accept = `in_valid` AND `in_ready`.
- On accept:
  - slot[dest] loads `in_data` and sets valid.
  - The other slot is untouched.
- Output drain:
  - slot valid AND ready with no reload into it: valid clears, data holds its last value.
- Same slot drains and loads in one cycle: data is replaced, valid stays 1, no bubble.
- The two slots operate independently. A may drain while B loads, and vice versa.
- Counters:
  - `a_cnt` increments on `a_valid & a_ready`; `b_cnt` likewise for B.
  - Both are 8-bit and wrap 255 -> 0 with no flag.
- `in_valid` low: no state change in the slots. Drains still occur.
- `in_sel` may change while `in_valid` is low. While `in_valid` is high and `in_ready` is low, the source must hold `in_data` and `in_sel` stable.

## Timing
- Reset values (applied at the first `clk` edge with `rst` = 1):
  - `a_valid` = `b_valid` = 0, `a_data` = `b_data` = 0.
  - `a_cnt` = `b_cnt` = 0, `rr_ptr` = A.
  - `in_ready` then evaluates to 1.
- `rst` asserted mid-operation discards held data. Handshakes in the reset cycle are neither completed nor counted.
- Latency: input accepted at edge N appears on `*_data`/`*_valid` after edge N, so it is consumable in cycle N+1.
- Throughput: one transfer per cycle per destination when its consumer holds ready high.
- `a_data`, `a_valid`, `b_data`, `b_valid`, `a_cnt` and `b_cnt` are driven directly from flops.

## Configuration
- Macro `SCALE_DEMUX_RR_EN`.
- Defined: round-robin distribution.
  - `in_sel` is unused.
  - `rr_ptr` toggles A <-> B after each accepted input and holds otherwise.
  - A stalled destination stalls the source. It does not skip to the other destination.
- Undefined: `rr_ptr` logic is not built, and steering is by `in_sel` only.

## Structure
- Package `scale_demux_pkg`:
  - `DEST_A` = 1'b0, `DEST_B` = 1'b1.
  - `DEMUX_WIDTH_DEF` = 8.
  - `CNT_W` = 8.
- Sub-module `demux_slot`: one-entry holding register with load, drain and count. Instantiated twice, once per destination.
- Top level holds dest select, `in_ready` mux and `rr_ptr`.

## Test plan
- Reset, then idle with `a_ready` = `b_ready` = 1: all outputs 0, `in_ready` = 1.
- `in_sel` = 0, `in_data` = 8'hFF, `in_valid` pulse, `a_ready` = 1: `a_valid` = 1 with `a_data` = 8'hFF next cycle for one cycle. `b_valid` stays 0. `a_cnt` = 1.
- `b_ready` = 0, two consecutive writes to B (8'h00 then 8'h55): first write accepted. `in_ready` = 0 while `in_sel` = 1. Switching `in_sel` to 0 raises `in_ready`, and 8'hAA delivers to A while B holds 8'h00.
- Streaming 4 words to A with `a_ready` = 1 continuously: `a_valid` stays high for 4 cycles with no bubble, data in order, `a_cnt` = 4.
- 256 A handshakes: `a_cnt` wraps to 0. Asserting `rst` with both slots full clears valids, data and counters at the next edge.
- `SCALE_DEMUX_RR_EN` defined, inputs 1,2,3,4 with `in_sel` = 1 throughout: A receives 1,3 and B receives 2,4. With `b_ready` = 0, the source stalls after the word 2 slot fills.
